// File: rtl/token_mult_pkg.sv
// Shared types and width helpers for the serial token multiplier.
// Widths are derived from parameters so counters never wrap.
package token_mult_pkg;

  // Sticky error cause: bit1 = pending-storage overflow, bit0 = run overflow.
  typedef struct packed {
    logic pend;
    logic run;
  } ovf_cause_t;

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_OVF    = 1'b1
  } tm_state_t;

  function automatic int pend_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int run_w(input int max_run);
    return $clog2(max_run + 1);
  endfunction

endpackage

// File: rtl/token_mult_sat_counter.sv
// Saturating up-counter with synchronous clear; holds its value when neither
// increment nor clear is requested.
module sat_counter #(
  parameter int W   = 8,
  parameter int MAX = 200
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count,
  output logic         o_at_max
);

  logic [W-1:0] r_count;

  assign o_count  = r_count;
  assign o_at_max = (r_count == W'(MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !o_at_max) begin
      r_count <= r_count + W'(1);
    end
  end

endmodule

// File: rtl/token_multiplier.sv
// Serial token expander: every '1' on a becomes factor consecutive '1's on b,
// with sticky run-overflow and pending-overflow detection.
module token_multiplier
  import token_mult_pkg::*;
#(
  parameter int FACTOR_W   = 2,
  parameter int MAX_RUN    = 200,
  parameter int PEND_DEPTH = 400
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           a,
  input  logic [FACTOR_W-1:0]                            factor,
  output logic                                           b,
  output logic                                           overflow,
  output logic [1:0]                                     ovf_cause,
  output logic [token_mult_pkg::pend_w(PEND_DEPTH)-1:0]  pending
);

  localparam int PW = pend_w(PEND_DEPTH);
  localparam int RW = run_w(MAX_RUN);
  // Wide enough that pending + f_use - 1 can never wrap before the compare.
  localparam int EW = PW + FACTOR_W + 1;

  if (MAX_RUN < 1) begin : g_bad_max_run
    $error("token_multiplier: MAX_RUN must be >= 1");
  end
  if (PEND_DEPTH < 1) begin : g_bad_pend_depth
    $error("token_multiplier: PEND_DEPTH must be >= 1");
  end
  if (FACTOR_W < 1) begin : g_bad_factor_w
    $error("token_multiplier: FACTOR_W must be >= 1");
  end

  tm_state_t           r_state, w_state_nxt;
  logic                r_b, w_b_nxt;
  ovf_cause_t          r_cause, w_cause_nxt;
  logic [PW-1:0]       r_pending, w_pending_nxt;
  logic [FACTOR_W-1:0] r_factor_q, w_factor_q_nxt;

  logic [RW-1:0]       w_run;
  logic                w_run_at_max;
  logic                w_run_inc;
  logic                w_run_clr;
  logic                w_idle;
  logic [FACTOR_W-1:0] w_factor_eff;
  logic [FACTOR_W-1:0] w_f_use;
  logic [EW-1:0]       w_pend_sum;
  logic                w_err_run;
  logic                w_err_pend;

  sat_counter #(
    .W   (RW),
    .MAX (MAX_RUN)
  ) u_run_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_inc    (w_run_inc),
    .i_clr    (w_run_clr),
    .o_count  (w_run),
    .o_at_max (w_run_at_max)
  );

  // factor is only sampled at burst start; the burst and its drain use factor_q.
  assign w_idle       = (w_run == '0) && (r_pending == '0);
  assign w_factor_eff = (factor == '0) ? FACTOR_W'(1) : factor;
  assign w_f_use      = w_idle ? w_factor_eff : r_factor_q;
  assign w_pend_sum   = EW'(r_pending) + EW'(w_f_use) - EW'(1);
  assign w_err_run    = a && w_run_at_max;
  assign w_err_pend   = a && (w_pend_sum > EW'(PEND_DEPTH));

  always_comb begin
    w_state_nxt    = r_state;
    w_b_nxt        = r_b;
    w_cause_nxt    = r_cause;
    w_pending_nxt  = r_pending;
    w_factor_q_nxt = r_factor_q;
    w_run_inc      = 1'b0;
    w_run_clr      = 1'b0;
    case (r_state)
      ST_ACTIVE: begin
        if (a) begin
          w_b_nxt = 1'b1;
          if (w_err_run || w_err_pend) begin
            w_state_nxt      = ST_OVF;
            w_cause_nxt.run  = r_cause.run  | w_err_run;
            w_cause_nxt.pend = r_cause.pend | w_err_pend;
          end else begin
            w_run_inc      = 1'b1;
            w_pending_nxt  = PW'(w_pend_sum);
            w_factor_q_nxt = w_f_use;
          end
        end else begin
          w_run_clr      = 1'b1;
          w_factor_q_nxt = w_f_use;
          if (r_pending != '0) begin
            w_b_nxt       = 1'b1;
            w_pending_nxt = r_pending - PW'(1);
          end else begin
            w_b_nxt = 1'b0;
          end
        end
      end
      ST_OVF: begin
        // Sticky until reset: everything frozen, b forced high.
        w_b_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = ST_OVF;
        w_b_nxt     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_ACTIVE;
      r_b        <= 1'b0;
      r_cause    <= '0;
      r_pending  <= '0;
      r_factor_q <= FACTOR_W'(1);
    end else begin
      r_state    <= w_state_nxt;
      r_b        <= w_b_nxt;
      r_cause    <= w_cause_nxt;
      r_pending  <= w_pending_nxt;
      r_factor_q <= w_factor_q_nxt;
    end
  end

  assign b         = r_b;
  assign overflow  = (r_state == ST_OVF);
  assign ovf_cause = r_cause;
  assign pending   = r_pending;

endmodule

// File: tb/tb_token_multiplier.sv
// Directed bench for token_multiplier: vector table for steady-state expansion,
// hand sequences for overflow and asynchronous reset corner cases.
module tb_token_multiplier;

  logic       clk;
  logic       rst_n;
  logic       a;
  logic [1:0] factor;
  logic       b;
  logic       overflow;
  logic [1:0] ovf_cause;
  logic [8:0] pending;

  logic       a2;
  logic [1:0] factor2;
  logic       b2;
  logic       overflow2;
  logic [1:0] ovf_cause2;
  logic [3:0] pending2;

  int total;
  int bad;

  typedef struct {
    logic       a;
    logic [1:0] f;
    logic       exp_b;
    int         exp_pend;
  } vec_t;

  vec_t vt[$];

  token_multiplier dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .factor    (factor),
    .b         (b),
    .overflow  (overflow),
    .ovf_cause (ovf_cause),
    .pending   (pending)
  );

  token_multiplier #(.PEND_DEPTH(10)) dut_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a2),
    .factor    (factor2),
    .b         (b2),
    .overflow  (overflow2),
    .ovf_cause (ovf_cause2),
    .pending   (pending2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    a = 1'b0; factor = 2'd1;
    a2 = 1'b0; factor2 = 2'd1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // drivers: inputs change on the falling edge, outputs sampled 1 time unit after the rising edge
  task automatic drive(input logic ai, input logic [1:0] fi);
    @(negedge clk);
    a = ai; factor = fi;
    @(posedge clk);
    #1;
  endtask

  task automatic drive2(input logic ai, input logic [1:0] fi);
    @(negedge clk);
    a2 = ai; factor2 = fi;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic ai, input logic [1:0] fi, input logic eb, input int ep);
    vec_t v;
    v.a = ai; v.f = fi; v.exp_b = eb; v.exp_pend = ep;
    vt.push_back(v);
  endtask

  initial begin
    logic [25:0] a_pat;
    logic [25:0] b_pat;
    int          p_pat[26];
    total = 0;
    bad   = 0;

    // factor=2 stream; expected b per step and owed count worked by hand
    a_pat = 26'b10010011000110100001100100;
    b_pat = 26'b11011011110111111001111110;
    p_pat = '{1,0,0,1,0,0,1,2,1,0,0,1,2,1,2,1,0,0,0,1,2,1,0,1,0,0};
    for (int i = 0; i < 26; i++) add_vec(a_pat[25-i], 2'd2, b_pat[25-i], p_pat[i]);
    // factor=3: two ones give six ones, pending peaks at 4
    add_vec(1'b1, 2'd3, 1'b1, 2);
    add_vec(1'b1, 2'd3, 1'b1, 4);
    add_vec(1'b0, 2'd3, 1'b1, 3);
    add_vec(1'b0, 2'd3, 1'b1, 2);
    add_vec(1'b0, 2'd3, 1'b1, 1);
    add_vec(1'b0, 2'd3, 1'b1, 0);
    add_vec(1'b0, 2'd3, 1'b0, 0);
    add_vec(1'b0, 2'd3, 1'b0, 0);
    // factor drops to 1 mid-burst: burst still yields 3 ones, next burst uses 1
    add_vec(1'b1, 2'd3, 1'b1, 2);
    add_vec(1'b0, 2'd1, 1'b1, 1);
    add_vec(1'b0, 2'd1, 1'b1, 0);
    add_vec(1'b0, 2'd1, 1'b0, 0);
    add_vec(1'b1, 2'd1, 1'b1, 0);
    add_vec(1'b0, 2'd1, 1'b0, 0);
    // factor=0 acts as 1
    add_vec(1'b1, 2'd0, 1'b1, 0);
    add_vec(1'b1, 2'd0, 1'b1, 0);
    add_vec(1'b0, 2'd0, 1'b0, 0);
    // factor=1 passthrough
    add_vec(1'b1, 2'd1, 1'b1, 0);
    add_vec(1'b0, 2'd1, 1'b0, 0);
    add_vec(1'b1, 2'd1, 1'b1, 0);
    add_vec(1'b1, 2'd1, 1'b1, 0);
    add_vec(1'b0, 2'd1, 1'b0, 0);

    do_reset();
    @(posedge clk); #1;
    check("reset b", b, 0);
    check("reset overflow", overflow, 0);
    check("reset cause", ovf_cause, 0);
    check("reset pending", pending, 0);
    check("reset pending small", pending2, 0);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].a, vt[i].f);
      check($sformatf("vec%0d b", i), b, vt[i].exp_b);
      check($sformatf("vec%0d pending", i), pending, vt[i].exp_pend);
      check($sformatf("vec%0d overflow", i), overflow, 0);
    end

    // run overflow: 200 ones accepted, the 201st trips the sticky flag
    do_reset();
    for (int i = 0; i < 200; i++) drive(1'b1, 2'd1);
    check("run200 overflow", overflow, 0);
    check("run200 b", b, 1);
    drive(1'b1, 2'd1);
    check("run201 overflow", overflow, 1);
    check("run201 cause", ovf_cause, 2'b01);
    check("run201 b", b, 1);
    for (int i = 0; i < 50; i++) begin
      drive(1'b0, 2'd3);
      check($sformatf("sticky%0d b", i), b, 1);
      check($sformatf("sticky%0d overflow", i), overflow, 1);
      check($sformatf("sticky%0d cause", i), ovf_cause, 2'b01);
      check($sformatf("sticky%0d pending", i), pending, 0);
    end
    do_reset();
    @(posedge clk); #1;
    check("run clr b", b, 0);
    check("run clr overflow", overflow, 0);
    check("run clr cause", ovf_cause, 0);
    check("run clr pending", pending, 0);

    // pending overflow on the PEND_DEPTH=10 instance
    for (int i = 1; i <= 5; i++) begin
      drive2(1'b1, 2'd3);
      check($sformatf("pend step%0d", i), pending2, 2 * i);
      check($sformatf("pend step%0d overflow", i), overflow2, 0);
    end
    drive2(1'b1, 2'd3);
    check("pend ovf overflow", overflow2, 1);
    check("pend ovf cause", ovf_cause2, 2'b10);
    check("pend ovf pending", pending2, 10);
    check("pend ovf b", b2, 1);
    for (int i = 0; i < 3; i++) begin
      drive2(1'b0, 2'd1);
      check($sformatf("pend frozen%0d pending", i), pending2, 10);
      check($sformatf("pend frozen%0d b", i), b2, 1);
      check($sformatf("pend frozen%0d cause", i), ovf_cause2, 2'b10);
    end

    // asynchronous reset with 5 tokens owed
    do_reset();
    drive(1'b1, 2'd3);
    drive(1'b1, 2'd3);
    drive(1'b1, 2'd3);
    drive(1'b0, 2'd3);
    check("pre-async pending", pending, 5);
    check("pre-async b", b, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async b", b, 0);
    check("async pending", pending, 0);
    check("async overflow small", overflow2, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
